// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: accepts WORD_W-bit words over a valid/ready handshake
// and serialises CHAIN_LEN bits MSB-first onto ccff_head, qualified by prog_clk_en.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  output logic              io_isol_n,
  output logic              busy,
  output logic              done
);

  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BIT_CW    = $clog2(CHAIN_LEN + 1);
  localparam int WBIT_CW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WORD_CW   = $clog2(NUM_WORDS + 1);

  localparam logic [BIT_CW-1:0]  LAST_BIT    = BIT_CW'(CHAIN_LEN - 1);
  localparam logic [WBIT_CW-1:0] LAST_WBIT   = WBIT_CW'(WORD_W - 1);
  localparam logic [WORD_CW-1:0] NUM_WORDS_C = WORD_CW'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                buf_valid_q, buf_valid_d;
  logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WBIT_CW-1:0]  word_bit_q, word_bit_d;
  logic [WORD_CW-1:0]  words_acc_q, words_acc_d;

  logic cfg_ready_q, cfg_ready_d;
  logic ccff_head_q, ccff_head_d;
  logic prog_clk_en_q, prog_clk_en_d;
  logic io_isol_n_q, io_isol_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic handshake;

  assign handshake = cfg_valid & cfg_ready_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    bit_cnt_d   = bit_cnt_q;
    word_bit_d  = word_bit_q;
    words_acc_d = words_acc_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = WAIT_WORD;
          shreg_d     = '0;
          buf_d       = '0;
          buf_valid_d = 1'b0;
          bit_cnt_d   = '0;
          word_bit_d  = '0;
          words_acc_d = '0;
        end
      end

      WAIT_WORD: begin
        if (handshake) begin
          shreg_d     = cfg_data;
          word_bit_d  = '0;
          words_acc_d = words_acc_q + WORD_CW'(1);
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        shreg_d    = shreg_q << 1;
        bit_cnt_d  = bit_cnt_q + BIT_CW'(1);
        word_bit_d = word_bit_q + WBIT_CW'(1);
        if (handshake) begin
          words_acc_d = words_acc_q + WORD_CW'(1);
        end

        if (bit_cnt_q == LAST_BIT) begin
          // Chain complete: any leftover LSBs of the final word are dropped here.
          state_d = DONE;
        end else if (word_bit_q == LAST_WBIT) begin
          word_bit_d = '0;
          if (buf_valid_q) begin
            shreg_d     = buf_q;
            buf_valid_d = 1'b0;
          end else if (handshake) begin
            // Word arriving on the boundary cycle goes straight to the shifter, no gap.
            shreg_d = cfg_data;
          end else begin
            state_d = WAIT_WORD;
          end
        end else if (handshake) begin
          buf_d       = cfg_data;
          buf_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    cfg_ready_d   = (state_d == WAIT_WORD) ||
                    ((state_d == SHIFT) && !buf_valid_d && (words_acc_d < NUM_WORDS_C));
    prog_clk_en_d = (state_d == SHIFT);
    ccff_head_d   = (state_d == SHIFT) && shreg_d[WORD_W-1];
    io_isol_n_d   = (state_d == DONE);
    busy_d        = (state_d == WAIT_WORD) || (state_d == SHIFT);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      buf_q         <= '0;
      buf_valid_q   <= 1'b0;
      bit_cnt_q     <= '0;
      word_bit_q    <= '0;
      words_acc_q   <= '0;
      cfg_ready_q   <= 1'b0;
      ccff_head_q   <= 1'b0;
      prog_clk_en_q <= 1'b0;
      io_isol_n_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      buf_q         <= buf_d;
      buf_valid_q   <= buf_valid_d;
      bit_cnt_q     <= bit_cnt_d;
      word_bit_q    <= word_bit_d;
      words_acc_q   <= words_acc_d;
      cfg_ready_q   <= cfg_ready_d;
      ccff_head_q   <= ccff_head_d;
      prog_clk_en_q <= prog_clk_en_d;
      io_isol_n_q   <= io_isol_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign ccff_head   = ccff_head_q;
  assign prog_clk_en = prog_clk_en_q;
  assign io_isol_n   = io_isol_n_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: expected chain bits are queued at load start, a monitor pops one
// per prog_clk_en cycle; directed tests cover timing, stalls, reset abort and reload.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: default parameters
  logic       start_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       valid_a = 1'b0;
  logic       ready_a, head_a, en_a, isol_a, busy_a, done_a;

  ccff_bitstream_loader u_dut_a (
    .prog_clk     (clk),
    .prog_reset_n (rst_n),
    .start        (start_a),
    .cfg_data     (data_a),
    .cfg_valid    (valid_a),
    .cfg_ready    (ready_a),
    .ccff_head    (head_a),
    .prog_clk_en  (en_a),
    .io_isol_n    (isol_a),
    .busy         (busy_a),
    .done         (done_a)
  );

  // DUT B: 16-bit chain, whole words only
  logic       start_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       valid_b = 1'b0;
  logic       ready_b, head_b, en_b, isol_b, busy_b, done_b;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_dut_b (
    .prog_clk     (clk),
    .prog_reset_n (rst_n),
    .start        (start_b),
    .cfg_data     (data_b),
    .cfg_valid    (valid_b),
    .cfg_ready    (ready_b),
    .ccff_head    (head_b),
    .prog_clk_en  (en_b),
    .io_isol_n    (isol_b),
    .busy         (busy_b),
    .done         (done_b)
  );

  bit exp_a[$];
  bit exp_b[$];
  int en_cnt_a, stall_cnt_a, first_en_a, last_en_a;
  int en_cnt_b;
  int start_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor A
  always @(negedge clk) begin
    if (en_a) begin
      en_cnt_a++;
      if (first_en_a < 0) first_en_a = cyc;
      last_en_a = cyc;
      if (exp_a.size() == 0) begin
        chk("a_extra_bit", 1, 0);
      end else begin
        bit b;
        b = exp_a.pop_front();
        chk("a_head_bit", int'(head_a), int'(b));
      end
    end else begin
      chk("a_head_idle", int'(head_a), 0);
    end
    if (busy_a && !en_a) stall_cnt_a++;
  end

  // Monitor B
  always @(negedge clk) begin
    if (en_b) begin
      en_cnt_b++;
      if (exp_b.size() == 0) begin
        chk("b_extra_bit", 1, 0);
      end else begin
        bit b;
        b = exp_b.pop_front();
        chk("b_head_bit", int'(head_b), int'(b));
      end
    end
  end

  task automatic push_a20();
    logic [19:0] v;
    v = 20'b1010_0101_0011_1100_1111;
    for (int i = 19; i >= 0; i--) exp_a.push_back(v[i]);
  endtask

  task automatic start_pulse_a();
    @(posedge clk); #1;
    start_a = 1'b1;
    start_cyc = cyc;
    en_cnt_a = 0; stall_cnt_a = 0; first_en_a = -1; last_en_a = -1;
    @(posedge clk); #1;
    start_a = 1'b0;
    // {busy, io_isol_n, done, cfg_ready} in the first WAIT_WORD cycle
    chk("a_after_start", int'({busy_a, isol_a, done_a, ready_a}), 4'b1001);
  endtask

  task automatic feed_a(input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    data_a = w;
    valid_a = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready_a) begin ok = 1'b1; break; end
    end
    if (!ok) chk("a_feed_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done_a(input string name, input int exp_rel);
    int rel;
    rel = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (done_a) begin rel = cyc - start_cyc; break; end
    end
    chk({name, "_done_cycle"}, rel, exp_rel);
    // {busy, io_isol_n, done, cfg_ready, prog_clk_en} in DONE
    chk({name, "_done_outs"}, int'({busy_a, isol_a, done_a, ready_a, en_a}), 5'b01100);
    chk({name, "_en_total"}, en_cnt_a, 20);
    chk({name, "_queue_left"}, exp_a.size(), 0);
  endtask

  task automatic full_load_a();
    push_a20();
    start_pulse_a();
    feed_a(8'hA5);
    feed_a(8'h3C);
    feed_a(8'hF0);
    valid_a = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en_cnt_a = 0; stall_cnt_a = 0; first_en_a = -1; last_en_a = -1; en_cnt_b = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs_a", int'({ready_a, head_a, en_a, isol_a, busy_a, done_a}), 0);
    chk("reset_outs_b", int'({ready_b, head_b, en_b, isol_b, busy_b, done_b}), 0);
    #2 rst_n = 1'b1;

    // cfg_valid while IDLE is ignored
    valid_a = 1'b1; data_a = 8'hFF;
    repeat (3) @(negedge clk);
    chk("idle_valid_ignored", int'({ready_a, busy_a, en_a}), 0);
    valid_a = 1'b0;

    // Back-to-back load
    full_load_a();
    wait_done_a("b2b", 22);
    chk("b2b_first_en", first_en_a - start_cyc, 2);
    chk("b2b_last_en", last_en_a - start_cyc, 21);
    chk("b2b_wait_cycles", stall_cnt_a, 1);

    // Stalled source: 5 idle enable cycles between word 1 and word 2
    push_a20();
    start_pulse_a();
    feed_a(8'hA5);
    feed_a(8'h3C);
    valid_a = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    feed_a(8'hF0);
    valid_a = 1'b0;
    wait_done_a("stall", 27);
    chk("stall_wait_cycles", stall_cnt_a, 6);

    // Reset mid-SHIFT after 9 bits
    push_a20();
    start_pulse_a();
    feed_a(8'hA5);
    feed_a(8'h3C);
    valid_a = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (en_cnt_a >= 9) break;
    end
    chk("rst_bits_before", en_cnt_a, 9);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", int'({ready_a, head_a, en_a, isol_a, busy_a, done_a}), 0);
    exp_a.delete();
    @(posedge clk); @(negedge clk);
    chk("rst_hold_outs", int'({ready_a, head_a, en_a, isol_a, busy_a, done_a}), 0);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_release_outs", int'({ready_a, head_a, en_a, isol_a, busy_a, done_a}), 0);
    full_load_a();
    wait_done_a("after_rst", 22);

    // Start while busy at cycle 7 is ignored
    push_a20();
    start_pulse_a();
    fork
      begin
        feed_a(8'hA5);
        feed_a(8'h3C);
        feed_a(8'hF0);
        valid_a = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
      end
    join
    wait_done_a("busy_start", 22);
    chk("busy_start_first_en", first_en_a - start_cyc, 2);
    chk("busy_start_last_en", last_en_a - start_cyc, 21);

    // DONE holds and ignores cfg_valid
    valid_a = 1'b1; data_a = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    chk("done_hold", int'({done_a, isol_a, ready_a, en_a, busy_a}), 5'b11000);
    valid_a = 1'b0;

    // Reload from DONE (start_pulse_a checks done=0 / io_isol_n=0 next cycle)
    full_load_a();
    wait_done_a("reload", 22);

    // 16-bit chain on DUT B
    begin
      logic [15:0] v;
      logic [7:0]  words [2];
      int          rel;
      v = 16'b1001_0110_0101_1010;
      for (int i = 15; i >= 0; i--) exp_b.push_back(v[i]);
      words[0] = 8'h96; words[1] = 8'h5A;
      @(posedge clk); #1;
      start_b = 1'b1; start_cyc = cyc; en_cnt_b = 0;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int w = 0; w < 2; w++) begin
        bit ok;
        ok = 1'b0;
        data_b = words[w]; valid_b = 1'b1;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (ready_b) begin ok = 1'b1; break; end
        end
        if (!ok) chk("b_feed_timeout", 0, 1);
        @(posedge clk); #1;
      end
      valid_b = 1'b0;
      rel = -1;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk); #1;
        if (done_b) begin rel = cyc - start_cyc; break; end
      end
      chk("b16_done_cycle", rel, 18);
      chk("b16_en_total", en_cnt_b, 16);
      chk("b16_queue_left", exp_b.size(), 0);
      chk("b16_isol", int'(isol_b), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, giving the width of an incoming configuration word.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 20, giving the total number of configuration-chain bits to shift.
REQ-003 The block SHALL derive NUM_WORDS = ceil(CHAIN_LEN / WORD_W), which is 3 at the defaults.
REQ-004 prog_clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-005 prog_reset_n  input  1  is an asynchronous, active-low reset.
REQ-006 start  input  1  is a one-cycle request to begin a configuration load.
REQ-007 cfg_data  input  WORD_W  is the configuration word; bit WORD_W-1 is the first bit shifted.
REQ-008 cfg_valid  input  1  indicates that cfg_data is valid.
REQ-009 cfg_ready  output  1  indicates the block accepts a word this cycle.
REQ-010 ccff_head  output  1  is the serial bit driven to the head of the configuration chain.
REQ-011 prog_clk_en  output  1  is high exactly on cycles where ccff_head carries a chain bit; downstream uses it to gate the chain shift.
REQ-012 io_isol_n  output  1  is the IO isolation control: 0 isolates the IO tiles, 1 releases them.
REQ-013 busy  output  1  is high while a load is in progress.
REQ-014 done  output  1  is high once CHAIN_LEN bits have been shifted, and stays high until the next start.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_WORD, SHIFT and DONE.
REQ-016 IDLE/DONE transitions on start=1:
- next state is WAIT_WORD;
- the bit counter, word counter and buffer are cleared;
- io_isol_n goes to 0 in the next cycle.
REQ-017 In WAIT_WORD:
- cfg_ready = 1 and prog_clk_en = 0;
- a handshake (cfg_valid & cfg_ready) loads cfg_data into the shift register and moves to SHIFT.
REQ-018 In SHIFT, ccff_head = shift register MSB and prog_clk_en = 1; each cycle the register shifts left by one and the bit counter increments.
REQ-019 Latency: a handshake in cycle t SHALL place bit WORD_W-1 on ccff_head with prog_clk_en=1 in cycle t+1.
REQ-020 In SHIFT, cfg_ready = !buf_valid && (words_accepted < NUM_WORDS); a handshake here fills the one-entry buffer.
REQ-021 When the last bit of a word is shifted:
- if CHAIN_LEN bits are complete, go to DONE;
- else if buf_valid, load the buffer into the shift register, clear buf_valid, and stay in SHIFT with no gap cycle;
- else go to WAIT_WORD.
REQ-022 For the final word, only the CHAIN_LEN - (NUM_WORDS-1)*WORD_W MSBs SHALL be shifted; the remaining LSBs are discarded.
REQ-023 ccff_head SHALL be 0 whenever prog_clk_en = 0.
REQ-024 busy SHALL be 1 in WAIT_WORD and SHIFT, and 0 in IDLE and DONE.
REQ-025 In DONE: done = 1, io_isol_n = 1, cfg_ready = 0, prog_clk_en = 0.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 cfg_valid in IDLE or DONE SHALL be ignored, since cfg_ready = 0 there.
REQ-028 The total count of prog_clk_en cycles per load SHALL equal CHAIN_LEN exactly; counters SHALL be wide enough for CHAIN_LEN with no wrap.
REQ-029 cfg_valid deasserted mid-load SHALL stall in WAIT_WORD indefinitely, with no timeout and no bits emitted.

Reset
REQ-030 On prog_reset_n = 0 the block SHALL asynchronously enter IDLE with these values:
- cfg_ready = 0, ccff_head = 0, prog_clk_en = 0;
- io_isol_n = 0, busy = 0, done = 0;
- buf_valid = 0 and all counters = 0.
REQ-031 Reset asserted mid-load SHALL abort the load immediately; the partial chain contents are not recovered, and a new start is required.
REQ-032 Reset deassertion SHALL take effect on the first prog_clk rising edge after release; outputs SHALL hold their reset values until then.

Verification
REQ-033 Back-to-back load: defaults, start at cycle 0, words 0xA5, 0x3C, 0xF0 always valid -> ccff_head = 10100101 00111100 1111 on 20 contiguous prog_clk_en cycles (2..21), DONE at 22 with done = 1 and io_isol_n = 1.
REQ-034 Stalled source: cfg_valid dropped for 5 cycles after word 1 -> prog_clk_en low for those cycles, the bit sequence is unchanged, and the total is still 20 enable cycles.
REQ-035 Reset mid-SHIFT after 9 bits -> all outputs are at reset values asynchronously; a subsequent start with a full load yields a correct 20-bit sequence.
REQ-036 Start while busy at cycle 7 -> no effect, and the sequence is identical to REQ-033.
REQ-037 Reload from DONE: start -> io_isol_n = 0 and done = 0 next cycle, then a second 20-bit load completes with done = 1 again.
REQ-038 Parameter sweep with CHAIN_LEN = 16, WORD_W = 8 -> 2 words, 16 enable cycles, and no partial-word discard.
